// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle between the PS/2 receiver, the scancode decoder and the CPU side.
// The decoder uses modport slave; the receiver/CPU side (or a bench) uses modport master.
interface ps2_scancode_decoder_if #(
  parameter int FIFO_AW = 3
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_parity_ok;
  logic               rx_ack;
  logic               ev_valid;
  logic [7:0]         ev_code;
  logic               ev_ext;
  logic               ev_break;
  logic               ev_pop;
  logic [FIFO_AW:0]   ev_count;
  logic               overflow;
  logic               ovf_clr;
  logic [7:0]         status_byte;
  logic               status_stb;
  logic               parity_err;

  modport slave (
    input  rx_valid, rx_data, rx_parity_ok, ev_pop, ovf_clr,
    output rx_ack, ev_valid, ev_code, ev_ext, ev_break, ev_count,
           overflow, status_byte, status_stb, parity_err
  );

  modport master (
    output rx_valid, rx_data, rx_parity_ok, ev_pop, ovf_clr,
    input  rx_ack, ev_valid, ev_code, ev_ext, ev_break, ev_count,
           overflow, status_byte, status_stb, parity_err
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: strips E0/F0/E1 prefixes and queues key events in a FWFT FIFO.
// Optional PS2DEC_REPEAT_FILTER_EN suppresses typematic repeats of the last make.
module ps2_scancode_decoder #(
  parameter int FIFO_AW = 3
) (
  input  logic                  clk,
  input  logic                  n_rst,
  ps2_scancode_decoder_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_e;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } event_t;

  logic               armed_q, armed_d, accept;
  logic               rx_ack_q;
  logic               byte_vld_q, par_ok_q;
  logic [7:0]         byte_q;
  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         status_byte_q;
  logic               status_stb_q, status_upd;
  logic               parity_err_q, par_fail;
  logic               overflow_q, ovf_set;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  event_t             cand, head;
  logic               cand_vld, push, do_push, do_pop, empty, full;
  event_t             mem [DEPTH];

  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                              is_status = 1'b0;
    endcase
  endfunction

  // A held byte re-arms the acceptor only once rx_valid has been seen low.
  assign accept  = bus.rx_valid && armed_q;
  assign armed_d = accept ? 1'b0 : (!bus.rx_valid ? 1'b1 : armed_q);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand       = '0;
    cand_vld   = 1'b0;
    status_upd = 1'b0;
    par_fail   = 1'b0;
    if (byte_vld_q) begin
      if (!par_ok_q) begin
        par_fail = 1'b1;
        state_d  = S_IDLE;
        cnt_d    = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_q == 8'hF0)      state_d = S_F0;
            else if (byte_q == 8'hE0) state_d = S_E0;
            else if (byte_q == 8'hE1) begin
              state_d = S_PAUSE;
              cnt_d   = '0;
            end else if (is_status(byte_q)) status_upd = 1'b1;
            else begin
              cand     = '{code: byte_q, ext: 1'b0, brk: 1'b0};
              cand_vld = 1'b1;
            end
          end
          S_E0: begin
            if (byte_q == 8'hF0) state_d = S_E0F0;
            else begin
              state_d  = S_IDLE;
              cand     = '{code: byte_q, ext: 1'b1, brk: 1'b0};
              cand_vld = (byte_q != 8'h12);
            end
          end
          S_F0: begin
            state_d  = S_IDLE;
            cand     = '{code: byte_q, ext: 1'b0, brk: 1'b1};
            cand_vld = 1'b1;
          end
          S_E0F0: begin
            state_d  = S_IDLE;
            cand     = '{code: byte_q, ext: 1'b1, brk: 1'b1};
            cand_vld = (byte_q != 8'h12);
          end
          S_PAUSE: begin
            if (cnt_q == 3'd6) begin
              state_d  = S_IDLE;
              cnt_d    = '0;
              cand     = '{code: 8'hE1, ext: 1'b1, brk: 1'b0};
              cand_vld = 1'b1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

`ifdef PS2DEC_REPEAT_FILTER_EN
  logic [8:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  logic       last_hit;

  assign last_hit = last_vld_q && (last_q == {cand.code, cand.ext});

  always_comb begin
    push       = cand_vld;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (cand_vld && !cand.brk) begin
      if (last_hit) push = 1'b0;
      else begin
        last_d     = {cand.code, cand.ext};
        last_vld_d = 1'b1;
      end
    end else if (cand_vld && last_hit) begin
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign push = cand_vld;
`endif

  assign empty   = (count_q == '0);
  assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = bus.ev_pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && full && !do_pop;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments only in clocked blocks, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      armed_q       <= 1'b1;
      rx_ack_q      <= 1'b0;
      byte_vld_q    <= 1'b0;
      byte_q        <= '0;
      par_ok_q      <= 1'b0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      status_byte_q <= '0;
      status_stb_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      armed_q      <= armed_d;
      rx_ack_q     <= accept;
      byte_vld_q   <= accept;
      if (accept) begin
        byte_q   <= bus.rx_data;
        par_ok_q <= bus.rx_parity_ok;
      end
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      status_stb_q <= status_upd;
      if (status_upd) status_byte_q <= byte_q;
      // A new error in the same cycle as the clear wins.
      parity_err_q <= par_fail || (parity_err_q && !bus.ovf_clr);
      overflow_q   <= ovf_set  || (overflow_q   && !bus.ovf_clr);
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q      <= count_d;
    end
  end

  // NOTE: storage is left unreset; empty gating below keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= cand;
  end

  assign head            = empty ? '0 : mem[rd_ptr_q];
  assign bus.rx_ack      = rx_ack_q;
  assign bus.ev_valid    = !empty;
  assign bus.ev_code     = head.code;
  assign bus.ev_ext      = head.ext;
  assign bus.ev_break    = head.brk;
  assign bus.ev_count    = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.status_byte = status_byte_q;
  assign bus.status_stb  = status_stb_q;
  assign bus.parity_err  = parity_err_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (FIFO_AW=3).
module tb_ps2_scancode_decoder;
  logic clk = 1'b0;
  logic n_rst;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ack_cnt = 0;
  int   stb_cnt = 0;
  logic valid_at_ack;

  ps2_scancode_decoder_if #(.FIFO_AW(3)) bus ();

  ps2_scancode_decoder #(.FIFO_AW(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_ack)     ack_cnt++;
    if (bus.status_stb) stb_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit par = 1'b1, input bit pop_at_ack = 1'b0);
    bit seen = 1'b0;
    @(negedge clk);
    bus.rx_valid     = 1'b1;
    bus.rx_data      = b;
    bus.rx_parity_ok = par;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.rx_ack) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 0, 1);
    valid_at_ack = bus.ev_valid;
    bus.rx_valid = 1'b0;
    bus.ev_pop   = pop_at_ack;
    @(negedge clk);
    bus.ev_pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    bus.ev_pop = 1'b1;
    @(negedge clk);
    bus.ev_pop = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [7:0] code, input logic ext,
                             input logic brk);
    check({tag, "_valid"}, bus.ev_valid, 1);
    check({tag, "_code"}, bus.ev_code, code);
    check({tag, "_extbrk"}, {bus.ev_ext, bus.ev_break}, {ext, brk});
    pop();
  endtask

  task automatic clr();
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
  endtask

  initial begin
    int a0, s0;
    logic [7:0] pause_seq [8];
    n_rst            = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = '0;
    bus.rx_parity_ok = 1'b1;
    bus.ev_pop       = 1'b0;
    bus.ovf_clr      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", bus.rx_ack, 0);
    check("rst_valid", bus.ev_valid, 0);
    check("rst_count", bus.ev_count, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_status", bus.status_byte, 0);
    check("rst_stb", bus.status_stb, 0);
    check("rst_code", bus.ev_code, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Plain make, with latency and single-ack check
    a0 = ack_cnt;
    send(8'h1C);
    check("make_valid_at_ack", valid_at_ack, 0);
    check("make_acks", ack_cnt - a0, 1);
    check("make_count", bus.ev_count, 1);
    expect_head("make", 8'h1C, 0, 0);
    check("make_popped", bus.ev_count, 0);

    send(8'hF0); send(8'h1C);
    expect_head("break", 8'h1C, 0, 1);
    send(8'hE0); send(8'h75);
    expect_head("ext_make", 8'h75, 1, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_head("ext_break", 8'h75, 1, 1);

    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    check("fake_shift_count", bus.ev_count, 1);
    expect_head("fake_shift", 8'h7C, 1, 0);

    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    s0 = stb_cnt;
    foreach (pause_seq[i]) send(pause_seq[i]);
    check("pause_count", bus.ev_count, 1);
    check("pause_no_stb", stb_cnt - s0, 0);
    expect_head("pause", 8'hE1, 1, 0);

    send(8'hFA);
    check("status_byte", bus.status_byte, 8'hFA);
    check("status_stb", stb_cnt - s0, 1);
    check("status_no_event", bus.ev_count, 0);

    // FIFO fill, simultaneous push/pop while full, then overflow
    for (int i = 0; i < 8; i++) send(8'h15 + 8'(i));
    check("full_count", bus.ev_count, 8);
    check("full_no_ovf", bus.overflow, 0);
    send(8'h1D, 1'b1, 1'b1);
    check("pushpop_count", bus.ev_count, 8);
    check("pushpop_no_ovf", bus.overflow, 0);
    send(8'h1E);
    check("ovf_count", bus.ev_count, 8);
    check("ovf_set", bus.overflow, 1);
    for (int i = 0; i < 8; i++) expect_head("drain", 8'h16 + 8'(i), 0, 0);
    check("drained_valid", bus.ev_valid, 0);
    pop();
    check("pop_empty_count", bus.ev_count, 0);
    check("pop_empty_valid", bus.ev_valid, 0);
    check("ovf_held", bus.overflow, 1);
    clr();
    check("ovf_cleared", bus.overflow, 0);

    // Parity error on second byte
    send(8'hF0); send(8'h1C, 1'b0);
    check("perr_set", bus.parity_err, 1);
    check("perr_no_event", bus.ev_count, 0);
    send(8'h1C);
    expect_head("after_perr", 8'h1C, 0, 0);
    clr();
    check("perr_cleared", bus.parity_err, 0);

    // Held rx_valid
    a0 = ack_cnt;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h2A;
    repeat (20) @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("held_acks", ack_cnt - a0, 1);
    check("held_count", bus.ev_count, 1);
    expect_head("held", 8'h2A, 0, 0);

    // Typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2DEC_REPEAT_FILTER_EN
    check("rep_count", bus.ev_count, 3);
    expect_head("rep0", 8'h1C, 0, 0);
    expect_head("rep1", 8'h1C, 0, 1);
    expect_head("rep2", 8'h1C, 0, 0);
`else
    check("rep_count", bus.ev_count, 5);
    expect_head("rep0", 8'h1C, 0, 0);
    expect_head("rep1", 8'h1C, 0, 0);
    expect_head("rep2", 8'h1C, 0, 0);
    expect_head("rep3", 8'h1C, 0, 1);
    expect_head("rep4", 8'h1C, 0, 0);
`endif
    check("rep_empty", bus.ev_valid, 0);

    // Reset in mid-sequence
    send(8'hE0);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    send(8'h75);
    check("midrst_count", bus.ev_count, 1);
    expect_head("midrst", 8'h75, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
